data_mem_arbiter: RTL and testbench

Shares the single-ported data memory between two requesters: execute-stage loads and committed-store drains from the store buffer. It grants at most one access per cycle. A saturating starvation counter and an urgency hint guarantee store forward progress. Load data is returned one cycle after the grant with the requester's tag. Load responses are killed on ROB mispredict. It sits in the commit stage between the store buffer, the execute memory port and data memory.

---
 rtl/data_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Purpose:
//   Shares the single-ported data memory between execute-stage loads and
//   committed-store drains coming from the store buffer. At most one access is
//   granted per cycle.
//
//   Loads normally win over stores, because a load sits on the critical path of
//   the pipeline. A store wins when any of the following holds:
//     - the store buffer raises its urgency hint;
//     - the store has lost STARVE_LIMIT consecutive arbitration cycles;
//     - no load is requesting;
//     - a flush is in progress (loads are not accepted then).
//
//   Load data comes back one cycle after the grant, together with the tag of
//   the load. A flush in the response cycle kills the response.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   ld_v_i/ld_addr_i/ld_tag_i   load request (valid, address, tag)
//   ld_ready_o              load granted this cycle
//   ld_rsp_v_o/_tag_o/_data_o   load response, one cycle after the grant
//   st_v_i/st_addr_i/st_data_i  store-drain request from the store buffer head
//   st_urgent_i             store buffer near full; the store takes priority
//   st_ready_o              store granted this cycle
//   flush_i                 ROB mispredict; blocks new loads, kills responses
//   mem_v_o/mem_w_o/mem_addr_o/mem_data_o  memory request (1 = write)
//   mem_r_data_i            memory read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int WORD_SIZE_P  = 16,
    parameter int LD_TAG_W     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    input  logic [LD_TAG_W-1:0]    ld_tag_i,
    output logic                   ld_ready_o,
    output logic                   ld_rsp_v_o,
    output logic [LD_TAG_W-1:0]    ld_rsp_tag_o,
    output logic [WORD_SIZE_P-1:0] ld_rsp_data_o,

    input  logic                   st_v_i,
    input  logic [WORD_SIZE_P-1:0] st_addr_i,
    input  logic [WORD_SIZE_P-1:0] st_data_i,
    input  logic                   st_urgent_i,
    output logic                   st_ready_o,

    input  logic                   flush_i,

    output logic                   mem_v_o,
    output logic                   mem_w_o,
    output logic [WORD_SIZE_P-1:0] mem_addr_o,
    output logic [WORD_SIZE_P-1:0] mem_data_o,
    input  logic [WORD_SIZE_P-1:0] mem_r_data_i
);

    localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // State
    logic [STARVE_W-1:0]  r_starve;
    logic                 r_rsp_v;
    logic [LD_TAG_W-1:0]  r_rsp_tag;

    // Arbitration
    logic w_starved;
    logic w_st_win;
    logic w_st_gnt;
    logic w_ld_gnt;
    logic w_rsp_v;

    assign w_starved = (r_starve == STARVE_MAX);

    // Stores win while a flush is active: loads cannot be accepted then, so
    // the free slot goes to the committed store.
    assign w_st_win = st_v_i & (st_urgent_i | w_starved | ~ld_v_i | flush_i);

    // Both grants are suppressed while reset is held.
    assign w_st_gnt = w_st_win & ~reset_i;
    assign w_ld_gnt = ld_v_i & ~w_st_win & ~flush_i & ~reset_i;

    assign st_ready_o = w_st_gnt;
    assign ld_ready_o = w_ld_gnt;

    // Memory port: the bus is driven to all-zero when idle. Loads do not
    // use the write-data lines, so those lines stay at zero during a read.
    always_comb begin
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (w_st_gnt) begin
            mem_v_o    = 1'b1;
            mem_w_o    = 1'b1;
            mem_addr_o = st_addr_i;
            mem_data_o = st_data_i;
        end else if (w_ld_gnt) begin
            mem_v_o    = 1'b1;
            mem_addr_o = ld_addr_i;
        end
    end

    // Starvation counter and response pipeline.
    // The counter is not cleared by a flush. A flush already forces the
    // store to win, so the counter clears through the grant path anyway.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_starve  <= '0;
            r_rsp_v   <= 1'b0;
            r_rsp_tag <= '0;
        end else begin
            if (!st_v_i || w_st_gnt) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + STARVE_W'(1);
            end
            r_rsp_v   <= w_ld_gnt;
            r_rsp_tag <= ld_tag_i;
        end
    end

    // A response in flight is killed by a flush in its return cycle.
    // It is also killed by reset, so that all outputs read zero while
    // reset is held. Tag and data are gated to zero when no response is
    // valid.
    assign w_rsp_v       = r_rsp_v & ~flush_i & ~reset_i;
    assign ld_rsp_v_o    = w_rsp_v;
    assign ld_rsp_tag_o  = w_rsp_v ? r_rsp_tag    : '0;
    assign ld_rsp_data_o = w_rsp_v ? mem_r_data_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        ld_v_i = 1'b0;
    logic [15:0] ld_addr_i = '0;
    logic [3:0]  ld_tag_i = '0;
    logic        ld_ready_o;
    logic        ld_rsp_v_o;
    logic [3:0]  ld_rsp_tag_o;
    logic [15:0] ld_rsp_data_o;
    logic        st_v_i = 1'b0;
    logic [15:0] st_addr_i = '0;
    logic [15:0] st_data_i = '0;
    logic        st_urgent_i = 1'b0;
    logic        st_ready_o;
    logic        flush_i = 1'b0;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic [15:0] mem_r_data_i = '0;

    always #5 clk_i = ~clk_i;

    data_mem_arbiter #(
        .WORD_SIZE_P (16),
        .LD_TAG_W    (4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ld_v_i       (ld_v_i),
        .ld_addr_i    (ld_addr_i),
        .ld_tag_i     (ld_tag_i),
        .ld_ready_o   (ld_ready_o),
        .ld_rsp_v_o   (ld_rsp_v_o),
        .ld_rsp_tag_o (ld_rsp_tag_o),
        .ld_rsp_data_o(ld_rsp_data_o),
        .st_v_i       (st_v_i),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_urgent_i  (st_urgent_i),
        .st_ready_o   (st_ready_o),
        .flush_i      (flush_i),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_r_data_i (mem_r_data_i)
    );

    // Simple synchronous memory: registered read, write on grant.
    logic [15:0] tb_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
        tb_mem[8'h10] = 16'hBEEF;
        for (int i = 0; i < 5; i++) tb_mem[8'h40 + i] = 16'h1000 + 16'(i);
        forever begin
            @(posedge clk_i);
            if (mem_v_o && mem_w_o)  tb_mem[mem_addr_o[7:0]] <= mem_data_o;
            if (mem_v_o && !mem_w_o) mem_r_data_i <= tb_mem[mem_addr_o[7:0]];
        end
    end

    // Directed vectors. gnt: 0 none, 1 load, 2 store. rsp: a response is
    // expected in the following cycle, carrying rsp_data and this load's tag.
    typedef struct {
        logic        ld_v;
        logic [15:0] ld_addr;
        logic [3:0]  ld_tag;
        logic        st_v;
        logic [15:0] st_addr;
        logic [15:0] st_data;
        logic        urg;
        logic        flush;
        logic        rst;
        int          gnt;
        logic        rsp;
        logic [15:0] rsp_data;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        w;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ldr;
        logic        str;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [15:0] data;
    } rsp_exp_t;

    vec_t     vecs[$];
    mem_exp_t mq[$];
    rsp_exp_t rq[$];

    int checks = 0;
    int errors = 0;
    int cur_cyc = -1;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    task automatic add(input logic ld_v, input logic [15:0] ld_addr, input logic [3:0] ld_tag,
                       input logic st_v, input logic [15:0] st_addr, input logic [15:0] st_data,
                       input logic urg, input logic flush, input logic rst,
                       input int gnt, input logic rsp, input logic [15:0] rsp_data);
        vec_t v;
        v.ld_v = ld_v; v.ld_addr = ld_addr; v.ld_tag = ld_tag;
        v.st_v = st_v; v.st_addr = st_addr; v.st_data = st_data;
        v.urg = urg; v.flush = flush; v.rst = rst;
        v.gnt = gnt; v.rsp = rsp; v.rsp_data = rsp_data;
        vecs.push_back(v);
    endtask

    task automatic idle();
        add(0, 16'h0, 4'h0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (mem_v_o) begin
                if (mq.size() == 0) begin
                    chk("mem_unexpected_access", {47'h0, mem_w_o, mem_addr_o}, 64'h0);
                end else begin
                    mem_exp_t m;
                    m = mq.pop_front();
                    chk("mem_cycle", 64'(cur_cyc), 64'(m.cyc));
                    chk("mem_w", {63'h0, mem_w_o}, {63'h0, m.w});
                    chk("mem_addr", {48'h0, mem_addr_o}, {48'h0, m.addr});
                    if (m.w) chk("mem_data", {48'h0, mem_data_o}, {48'h0, m.data});
                    chk("grants", {62'h0, ld_ready_o, st_ready_o}, {62'h0, m.ldr, m.str});
                end
            end else begin
                chk("idle_bus", {29'h0, mem_w_o, mem_addr_o, mem_data_o, ld_ready_o, st_ready_o}, 64'h0);
                if (mq.size() != 0 && mq[0].cyc == cur_cyc) begin
                    void'(mq.pop_front());
                    chk("mem_missing_grant", 64'h0, 64'h1);
                end
            end
            if (ld_rsp_v_o) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", {44'h0, ld_rsp_tag_o, ld_rsp_data_o}, 64'h0);
                end else begin
                    rsp_exp_t r;
                    r = rq.pop_front();
                    chk("rsp_cycle", 64'(cur_cyc), 64'(r.cyc));
                    chk("rsp_tag", {60'h0, ld_rsp_tag_o}, {60'h0, r.tag});
                    chk("rsp_data", {48'h0, ld_rsp_data_o}, {48'h0, r.data});
                end
            end else if (rq.size() != 0 && rq[0].cyc == cur_cyc) begin
                void'(rq.pop_front());
                chk("rsp_missing", 64'h0, 64'h1);
            end
        end
    end

    initial begin
        // Reset with both requesters active: nothing may be granted.
        add(1, 16'h0010, 4'h1, 1, 16'h0020, 16'h9999, 0, 0, 1, 0, 0, 16'h0);
        add(1, 16'h0010, 4'h1, 1, 16'h0020, 16'h9999, 0, 0, 1, 0, 0, 16'h0);
        idle();
        // Load only.
        add(1, 16'h0010, 4'h3, 0, 16'h0, 16'h0, 0, 0, 0, 1, 1, 16'hBEEF);
        idle();
        // Starvation: four loads win, then the store, then the load again.
        for (int i = 0; i < 4; i++)
            add(1, 16'h0040 + 16'(i), 4'(i), 1, 16'h0050, 16'h5555, 0, 0, 0, 1, 1, 16'h1000 + 16'(i));
        add(1, 16'h0044, 4'h4, 1, 16'h0050, 16'h5555, 0, 0, 0, 2, 0, 16'h0);
        add(1, 16'h0044, 4'h4, 1, 16'h0050, 16'h5555, 0, 0, 0, 1, 1, 16'h1004);
        idle();
        add(1, 16'h0050, 4'h1, 0, 16'h0, 16'h0, 0, 0, 0, 1, 1, 16'h5555);
        idle();
        // Urgent store beats a load; a following load observes the store.
        add(1, 16'h0010, 4'h5, 1, 16'h0020, 16'h1234, 1, 0, 0, 2, 0, 16'h0);
        add(1, 16'h0020, 4'h6, 0, 16'h0, 16'h0, 0, 0, 0, 1, 1, 16'h1234);
        idle();
        // Flush in grant cycle; then flush in the response cycle.
        add(1, 16'h0010, 4'h7, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0, 16'h0);
        add(1, 16'h0010, 4'h7, 0, 16'h0, 16'h0, 0, 0, 0, 1, 0, 16'h0);
        add(0, 16'h0, 4'h0, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0, 16'h0);
        idle();
        // Flush with a store pending: the store is granted and written.
        add(1, 16'h0010, 4'h2, 1, 16'h0060, 16'hCAFE, 0, 1, 0, 2, 0, 16'h0);
        add(1, 16'h0060, 4'h8, 0, 16'h0, 16'h0, 0, 0, 0, 1, 1, 16'hCAFE);
        idle();
        // Build starvation to the limit, then reset mid-operation.
        for (int i = 0; i < 3; i++)
            add(1, 16'h0040 + 16'(i), 4'(i), 1, 16'h0070, 16'h7777, 0, 0, 0, 1, 1, 16'h1000 + 16'(i));
        add(1, 16'h0010, 4'h9, 1, 16'h0070, 16'h7777, 0, 0, 0, 1, 0, 16'h0);
        add(1, 16'h0010, 4'h9, 1, 16'h0070, 16'h7777, 0, 0, 1, 0, 0, 16'h0);
        add(1, 16'h0010, 4'h9, 1, 16'h0070, 16'h7777, 0, 0, 1, 0, 0, 16'h0);
        // The counter restarted: the load wins again.
        add(1, 16'h0010, 4'hA, 1, 16'h0070, 16'h7777, 0, 0, 0, 1, 1, 16'hBEEF);
        add(0, 16'h0, 4'h0, 1, 16'h0070, 16'h7777, 0, 0, 0, 2, 0, 16'h0);
        add(1, 16'h0070, 4'hB, 0, 16'h0, 16'h0, 0, 0, 0, 1, 1, 16'h7777);
        idle();
        idle();

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            @(posedge clk_i);
            #1;
            reset_i     = v.rst;
            ld_v_i      = v.ld_v;
            ld_addr_i   = v.ld_addr;
            ld_tag_i    = v.ld_tag;
            st_v_i      = v.st_v;
            st_addr_i   = v.st_addr;
            st_data_i   = v.st_data;
            st_urgent_i = v.urg;
            flush_i     = v.flush;
            cur_cyc     = k;
            mon_en      = 1'b1;
            if (v.gnt == 1) begin
                mq.push_back('{cyc: k, w: 1'b0, addr: v.ld_addr, data: 16'h0, ldr: 1'b1, str: 1'b0});
            end else if (v.gnt == 2) begin
                mq.push_back('{cyc: k, w: 1'b1, addr: v.st_addr, data: v.st_data, ldr: 1'b0, str: 1'b1});
            end
            if (v.rsp) rq.push_back('{cyc: k + 1, tag: v.ld_tag, data: v.rsp_data});
            $display("cycle %0d: rst=%0d ld_v=%0d ld_addr=%h st_v=%0d st_addr=%h urg=%0d flush=%0d exp_gnt=%0d",
                     k, v.rst, v.ld_v, v.ld_addr, v.st_v, v.st_addr, v.urg, v.flush, v.gnt);
        end
        @(posedge clk_i);
        #1;
        cur_cyc = vecs.size();
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        chk("mem_queue_drained", 64'(mq.size()), 64'h0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
